// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and external memory signals around cache_mem_arbiter.
// slave = arbiter side, master = caches/memory side.
interface cache_mem_arbiter_if #(
  parameter int BEAT_W = 2
);
  // Handshakes: a cache holds iXReq until its one-cycle oXDone pulse; the arbiter
  // holds oMReq with oMAddr/oMRW/oMWData stable until a cycle with iMAck high,
  // and that cycle transfers exactly one word. iMAck outside a request is ignored.
  logic              iIReq;
  logic [31:0]       iIAddr;
  logic              oIGnt;
  logic              oIBeat;
  logic [31:0]       oIData;
  logic              oIDone;

  logic              iDReq;
  logic              iDRW;
  logic [31:0]       iDAddr;
  logic [31:0]       iDWData;
  logic              oDGnt;
  logic              oDBeat;
  logic [31:0]       oDData;
  logic              oDDone;

  logic [BEAT_W-1:0] oBeatIdx;

  logic              oMReq;
  logic              oMRW;
  logic [31:0]       oMAddr;
  logic [31:0]       oMWData;
  logic              iMAck;
  logic [31:0]       iMRData;

  logic [1:0]        oDbgState;

  modport slave (
    input  iIReq, iIAddr,
    output oIGnt, oIBeat, oIData, oIDone,
    input  iDReq, iDRW, iDAddr, iDWData,
    output oDGnt, oDBeat, oDData, oDDone,
    output oBeatIdx,
    output oMReq, oMRW, oMAddr, oMWData,
    input  iMAck, iMRData,
    output oDbgState
  );

  modport master (
    output iIReq, iIAddr,
    input  oIGnt, oIBeat, oIData, oIDone,
    output iDReq, iDRW, iDAddr, iDWData,
    input  oDGnt, oDBeat, oDData, oDDone,
    input  oBeatIdx,
    input  oMReq, oMRW, oMAddr, oMWData,
    output iMAck, iMRData,
    input  oDbgState
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Line-burst arbiter between I/D caches and one shared word-wide memory port.
// Define CACHE_ARB_RR_EN for round-robin ties; otherwise D-cache wins ties.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_W     = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  cache_mem_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [31:0]       LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rw_q, rw_d;
  logic [31:0]       base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              ibeat_q, ibeat_d;
  logic              dbeat_q, dbeat_d;
  logic [31:0]       idata_q, idata_d;
  logic [31:0]       ddata_q, ddata_d;

  logic any_req;
  logic d_wins;

  assign any_req = bus.iIReq | bus.iDReq;

`ifdef CACHE_ARB_RR_EN
  logic last_q;

  // On a tie the side not served last wins; last_q resets to I, so the first tie goes to D.
  always_comb begin
    d_wins = bus.iDReq;
    if (bus.iIReq && bus.iDReq) begin
      d_wins = ~last_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      last_q <= OWN_I;
    end else if (state_q == ST_IDLE && any_req) begin
      last_q <= d_wins;
    end
  end
`else
  always_comb begin
    d_wins = bus.iDReq;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rw_d    = rw_q;
    base_d  = base_q;
    beat_d  = beat_q;
    ibeat_d = 1'b0;
    dbeat_d = 1'b0;
    idata_d = idata_q;
    ddata_d = ddata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BURST;
          owner_d = d_wins ? OWN_D : OWN_I;
          rw_d    = d_wins ? bus.iDRW : 1'b1;
          base_d  = (d_wins ? bus.iDAddr : bus.iIAddr) & LINE_MASK;
          beat_d  = '0;
        end
      end

      ST_BURST: begin
        if (bus.iMAck) begin
          if (owner_q == OWN_D) begin
            dbeat_d = 1'b1;
            if (rw_q) begin
              ddata_d = bus.iMRData;
            end
          end else begin
            ibeat_d = 1'b1;
            idata_d = bus.iMRData;
          end

          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      rw_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      ibeat_q <= 1'b0;
      dbeat_q <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      ibeat_q <= ibeat_d;
      dbeat_q <= dbeat_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
    end
  end

  logic in_burst;
  logic busy;

  // All outputs decode from registered state, so an async reset zeroes them immediately.
  assign in_burst = (state_q == ST_BURST);
  assign busy     = (state_q != ST_IDLE);

  assign bus.oIGnt    = busy && (owner_q == OWN_I);
  assign bus.oDGnt    = busy && (owner_q == OWN_D);
  assign bus.oIDone   = (state_q == ST_DONE) && (owner_q == OWN_I);
  assign bus.oDDone   = (state_q == ST_DONE) && (owner_q == OWN_D);
  assign bus.oIBeat   = ibeat_q;
  assign bus.oDBeat   = dbeat_q;
  assign bus.oIData   = idata_q;
  assign bus.oDData   = ddata_q;
  assign bus.oBeatIdx = beat_q;

  assign bus.oMReq   = in_burst;
  assign bus.oMRW    = in_burst && rw_q;
  assign bus.oMAddr  = in_burst ? (base_q + (32'(beat_q) << 2)) : 32'd0;
  assign bus.oMWData = (in_burst && (owner_q == OWN_D) && !rw_q) ? bus.iDWData : 32'd0;

  assign bus.oDbgState = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (default build: fixed D-over-I priority).
module tb_cache_mem_arbiter;

  localparam int LINE_WORDS = 4;
  localparam int BEAT_W     = 2;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;

  cache_mem_arbiter_if #(.BEAT_W(BEAT_W)) bus ();

  cache_mem_arbiter #(
    .LINE_WORDS (LINE_WORDS),
    .BEAT_W     (BEAT_W)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [31:0] rdat(input logic [31:0] base, input int k);
    return 32'hBEEF_0000 ^ (base + 32'(4 * k));
  endfunction

  function automatic logic [31:0] wdat(input int k);
    return 32'hDA7A_0000 + 32'(k);
  endfunction

  task automatic drive_idle();
    bus.iIReq   = 1'b0;
    bus.iIAddr  = 32'd0;
    bus.iDReq   = 1'b0;
    bus.iDRW    = 1'b0;
    bus.iDAddr  = 32'd0;
    bus.iDWData = 32'd0;
    bus.iMAck   = 1'b0;
    bus.iMRData = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 32'({bus.oIGnt, bus.oIBeat, bus.oIDone, bus.oDGnt, bus.oDBeat,
                                bus.oDDone, bus.oMReq, bus.oMRW}), 32'd0);
    check({tag, "_beatidx"}, 32'(bus.oBeatIdx), 32'd0);
    check({tag, "_maddr"}, bus.oMAddr, 32'd0);
    check({tag, "_mwdata"}, bus.oMWData, 32'd0);
    check({tag, "_idata"}, bus.oIData, 32'd0);
    check({tag, "_ddata"}, bus.oDData, 32'd0);
    check({tag, "_state"}, 32'(bus.oDbgState), 32'd0);
  endtask

  // Called in the first BURST cycle; zero-wait read burst, ending one cycle into IDLE.
  task automatic run_read(input bit is_d, input logic [31:0] base, input int drop_at);
    logic [31:0] exp_d;
    for (int k = 0; k < LINE_WORDS; k++) begin
      check("rd_gnt", 32'(is_d ? bus.oDGnt : bus.oIGnt), 32'd1);
      check("rd_other_gnt", 32'(is_d ? bus.oIGnt : bus.oDGnt), 32'd0);
      check("rd_mreq", 32'(bus.oMReq), 32'd1);
      check("rd_mrw", 32'(bus.oMRW), 32'd1);
      check("rd_maddr", bus.oMAddr, base + 32'(4 * k));
      check("rd_beatidx", 32'(bus.oBeatIdx), 32'(k));
      check("rd_done_early", 32'(is_d ? bus.oDDone : bus.oIDone), 32'd0);
      if (k > 0) begin
        exp_d = exp_q.pop_front();
        check("rd_beat", 32'(is_d ? bus.oDBeat : bus.oIBeat), 32'd1);
        check("rd_data", is_d ? bus.oDData : bus.oIData, exp_d);
      end else begin
        check("rd_beat_first", 32'(is_d ? bus.oDBeat : bus.oIBeat), 32'd0);
      end
      if (k == drop_at) begin
        if (is_d) bus.iDReq = 1'b0;
        else      bus.iIReq = 1'b0;
      end
      bus.iMAck   = 1'b1;
      bus.iMRData = rdat(base, k);
      exp_q.push_back(rdat(base, k));
      tick();
    end
    exp_d = exp_q.pop_front();
    check("done_pulse", 32'(is_d ? bus.oDDone : bus.oIDone), 32'd1);
    check("done_gnt", 32'(is_d ? bus.oDGnt : bus.oIGnt), 32'd1);
    check("done_mreq", 32'(bus.oMReq), 32'd0);
    check("done_beat", 32'(is_d ? bus.oDBeat : bus.oIBeat), 32'd1);
    check("done_data", is_d ? bus.oDData : bus.oIData, exp_d);
    check("done_beatidx_wrap", 32'(bus.oBeatIdx), 32'd0);
    if (is_d) bus.iDReq = 1'b0;
    else      bus.iIReq = 1'b0;
    bus.iMAck = 1'b0;
    tick();
    check("idle_gnt", 32'({bus.oIGnt, bus.oDGnt}), 32'd0);
    check("idle_done", 32'({bus.oIDone, bus.oDDone}), 32'd0);
    check("idle_mreq", 32'(bus.oMReq), 32'd0);
    check("idle_state", 32'(bus.oDbgState), 32'd0);
  endtask

  int done_cnt;

  initial begin
    drive_idle();

    // T1a: reset while idle
    #12;
    check_all_zero("rst_idle");
    tick();
    iRST = 1'b1;
    tick();
    check_all_zero("post_rst");

    // Stray acks and no request: nothing moves
    bus.iMAck   = 1'b1;
    bus.iMRData = 32'hFFFF_FFFF;
    repeat (3) tick();
    check_all_zero("stray_ack");
    bus.iMAck = 1'b0;

    // T2: I refill, unaligned 0x104 -> line 0x100
    bus.iIReq  = 1'b1;
    bus.iIAddr = 32'h0000_0104;
    tick();
    run_read(1'b0, 32'h0000_0100, -1);
    check("t2_idata_hold", bus.oIData, 32'hBEEF_010C ^ 32'h0000_0000);

    // T3: D write-back with two stall cycles per beat
    bus.iDReq  = 1'b1;
    bus.iDRW   = 1'b0;
    bus.iDAddr = 32'h0000_2000;
    tick();
    done_cnt = 0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      for (int w = 0; w < 3; w++) begin
        bus.iDWData = wdat(int'(bus.oBeatIdx));
        bus.iMAck   = (w == 2);
        #1;
        check("wb_gnt", 32'(bus.oDGnt), 32'd1);
        check("wb_mreq", 32'(bus.oMReq), 32'd1);
        check("wb_mrw", 32'(bus.oMRW), 32'd0);
        check("wb_maddr", bus.oMAddr, 32'h0000_2000 + 32'(4 * k));
        check("wb_mwdata", bus.oMWData, wdat(k));
        check("wb_dbeat", 32'(bus.oDBeat), 32'(k > 0 && w == 0));
        done_cnt += int'(bus.oDDone);
        tick();
      end
    end
    check("wb_last_beat", 32'(bus.oDBeat), 32'd1);
    check("wb_done", 32'(bus.oDDone), 32'd1);
    check("wb_done_mwdata", bus.oMWData, 32'd0);
    done_cnt += int'(bus.oDDone);
    bus.iDReq = 1'b0;
    bus.iMAck = 1'b0;
    tick();
    done_cnt += int'(bus.oDDone);
    check("wb_done_once", 32'(done_cnt), 32'd1);
    check("wb_no_read_capture", bus.oDData, 32'd0);
    check("wb_idle_gnt", 32'(bus.oDGnt), 32'd0);

    // T4: simultaneous requests -> D first, one idle cycle, then I
    bus.iIReq  = 1'b1;
    bus.iIAddr = 32'h0000_0400;
    bus.iDReq  = 1'b1;
    bus.iDRW   = 1'b1;
    bus.iDAddr = 32'h0000_3004;
    tick();
    run_read(1'b1, 32'h0000_3000, -1);
    check("tie_i_still_req", 32'(bus.oIGnt), 32'd0);
    tick();
    run_read(1'b0, 32'h0000_0400, -1);
    check("tie_ddata_hold", bus.oDData, 32'hBEEF_0000 ^ 32'h0000_300C);

    // T6: D refill with request dropped after beat 1
    bus.iDReq  = 1'b1;
    bus.iDRW   = 1'b1;
    bus.iDAddr = 32'h0000_5008;
    tick();
    run_read(1'b1, 32'h0000_5000, 2);
    tick();
    check("drop_stay_idle", 32'(bus.oDbgState), 32'd0);

    // T1b: reset in the middle of a D burst
    bus.iDReq  = 1'b1;
    bus.iDRW   = 1'b1;
    bus.iDAddr = 32'h0000_6000;
    tick();
    bus.iMAck   = 1'b1;
    bus.iMRData = 32'h1234_5678;
    tick();
    tick();
    check("pre_rst_beatidx", 32'(bus.oBeatIdx), 32'd2);
    #2;
    iRST = 1'b0;
    #1;
    check_all_zero("rst_burst");
    bus.iDReq = 1'b0;
    bus.iMAck = 1'b0;
    tick();
    iRST = 1'b1;
    tick();
    check_all_zero("post_rst_burst");
    tick();
    check("post_rst_mreq", 32'(bus.oMReq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
